// File: rtl/dff_bank_ctrl_if.sv
// ----------------------------------------------------------------------------
// dff_bank_ctrl_if
//
// Command/response bundle between a host sequencer and dff_bank_ctrl.
//
//   cmd_valid  host -> ctrl   command present
//   cmd_ready  ctrl -> host   controller can accept a command (IDLE, out of reset)
//   cmd_op     host -> ctrl   00 CLEAR, 01 LOAD, 10 SHIFT, 11 ROTATE
//   cmd_data   host -> ctrl   LOAD value, or shift count in the low CNT_W bits
//   rsp_valid  ctrl -> host   response present
//   rsp_ready  host -> ctrl   host accepts the response
//   rsp_data   ctrl -> host   bank contents at operation completion
//
// modport master : host / sequencer side
// modport slave  : controller side
// ----------------------------------------------------------------------------
interface dff_bank_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/dff_bank_ctrl.sv
// ----------------------------------------------------------------------------
// dff_bank_ctrl
//
// Command-driven controller for a WIDTH-bit bank of D flip-flops with
// true/complement outputs. One command at a time is taken over the cmd
// handshake (CLEAR, LOAD, SHIFT, ROTATE); the resulting bank contents are
// returned on the rsp handshake.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous active-low reset
//   bus    slave modport of dff_bank_ctrl_if (cmd/rsp handshakes)
//   si     in   serial input, sampled on each SHIFT edge
//   so     out  serial output, q[WIDTH-1]
//   q      out  bank contents
//   qb     out  complement of q
//   busy   out  high whenever the controller is not IDLE
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | bank frozen, cmd_ready high (when out of reset)
// SHIFTING  | one shift/rotate per edge, count register counts down to 0
// DONE      | rsp_valid high, bank frozen, waits for rsp_ready
// ----------------------------------------------------------------------------
module dff_bank_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    dff_bank_ctrl_if.slave   bus,
    input  logic             si,
    output logic             so,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy
);

    if (WIDTH < 2) begin : g_width_check
        $error("dff_bank_ctrl: WIDTH must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SHIFTING = 2'b01,
        ST_DONE     = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'b00,
        OP_LOAD   = 2'b01,
        OP_SHIFT  = 2'b10,
        OP_ROTATE = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bank_q,  bank_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rot_q,   rot_d;

    logic             cmd_accept;
    logic [CNT_W-1:0] cnt_req;
    logic [CNT_W-1:0] cnt_load;
    logic             shift_in;
    op_t              op;

    // ------------------------------------------------------------------
    // Handshake and status outputs
    // ------------------------------------------------------------------
    // cmd_ready is gated by reset so a host never sees a ready that the
    // reset edge would then discard.
    assign bus.cmd_ready = (state_q == ST_IDLE) && reset;
    assign bus.rsp_valid = (state_q == ST_DONE);
    // The bank is frozen in DONE, so the live bank is the completion value.
    // Reset clears the bank, which also gives rsp_data = 0 after reset.
    assign bus.rsp_data  = bank_q;

    assign busy = (state_q != ST_IDLE);
    assign q    = bank_q;
    assign qb   = ~bank_q;
    assign so   = bank_q[WIDTH-1];

    assign cmd_accept = bus.cmd_valid && bus.cmd_ready;
    assign op         = op_t'(bus.cmd_op);

    // Requested counts above WIDTH clamp to a full pass of the bank.
    assign cnt_req  = bus.cmd_data[CNT_W-1:0];
    assign cnt_load = (cnt_req > CNT_MAX) ? CNT_MAX : cnt_req;

    // ROTATE feeds the MSB back in; SHIFT takes the serial input.
    assign shift_in = rot_q ? bank_q[WIDTH-1] : si;

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (op)
                        OP_CLEAR: begin
                            bank_d  = '0;
                            state_d = ST_DONE;
                        end
                        OP_LOAD: begin
                            bank_d  = bus.cmd_data;
                            state_d = ST_DONE;
                        end
                        OP_SHIFT, OP_ROTATE: begin
                            cnt_d   = cnt_load;
                            rot_d   = (op == OP_ROTATE);
                            state_d = (cnt_load == '0) ? ST_DONE : ST_SHIFTING;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_SHIFTING: begin
                bank_d = {bank_q[WIDTH-2:0], shift_in};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Bank, count and operation registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_q <= '0;
            cnt_q  <= '0;
            rot_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            cnt_q  <= cnt_d;
            rot_q  <= rot_d;
        end
    end

endmodule
